// File: rtl/loop_sequencer.sv
// rtl/loop_sequencer.sv - issues loop iterations to a datapath one at a time over a valid/ready handshake
module loop_sequencer #(
  parameter int IDX_W = 8,
  parameter int C     = 2,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cfg_use_default,
  input  logic [IDX_W-1:0] cfg_count,
  input  logic             abort,
  output logic             iter_valid,
  output logic [IDX_W-1:0] iter_idx,
  input  logic             iter_ready,
  input  logic             iter_done,
  output logic             busy,
  output logic             finish,
  output logic             aborted,
  output logic [IDX_W-1:0] iter_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] trip_n;
  logic             zero_pend;
  logic [IDX_W-1:0] start_n;
  logic [IDX_W-1:0] cnt_inc;

  assign start_n = cfg_use_default ? IDX_W'(C) : cfg_count;
  assign cnt_inc = iter_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      trip_n     <= '0;
      zero_pend  <= 1'b0;
      iter_valid <= 1'b0;
      iter_idx   <= '0;
      busy       <= 1'b0;
      finish     <= 1'b0;
      aborted    <= 1'b0;
      iter_cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A zero-trip run spends one cycle in IDLE marked busy before it completes.
          if (zero_pend) begin
            state     <= DONE;
            zero_pend <= 1'b0;
            busy      <= 1'b0;
            finish    <= 1'b1;
          end else if (start) begin
            trip_n   <= start_n;
            iter_cnt <= '0;
            iter_idx <= '0;
            finish   <= 1'b0;
            aborted  <= 1'b0;
            busy     <= 1'b1;
            if (start_n == '0) begin
              state     <= IDLE;
              zero_pend <= 1'b1;
            end else begin
              state      <= ISSUE;
              iter_valid <= 1'b1;
            end
          end
        end

        ISSUE: begin
          if (abort) begin
            state      <= DONE;
            iter_valid <= 1'b0;
            busy       <= 1'b0;
            finish     <= 1'b1;
            aborted    <= 1'b1;
          end else if (iter_ready) begin
            state      <= WAIT;
            iter_valid <= 1'b0;
          end
        end

        WAIT: begin
          // Abort takes priority over a simultaneous completion, so the count stays frozen.
          if (abort) begin
            state   <= DONE;
            busy    <= 1'b0;
            finish  <= 1'b1;
            aborted <= 1'b1;
          end else if (iter_done) begin
            iter_cnt <= cnt_inc;
            if (cnt_inc == trip_n) begin
              state  <= DONE;
              busy   <= 1'b0;
              finish <= 1'b1;
            end else begin
              state      <= ISSUE;
              iter_idx   <= iter_idx + IDX_W'(STEP);
              iter_valid <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
